// File: rtl/pipe_skid32.sv
// -----------------------------------------------------------------------------
// pipe_skid32 - two-entry valid/ready skid buffer for the 32-bit datapath.
//
// Sits between a producer and a consumer. Back-pressure never forms a
// combinational path from out_ready to in_ready. When the consumer is not
// stalling, the block passes one word per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = in reset)
//   flush      synchronous clear; discards every held word and the word
//              offered on this edge
//   in_valid   producer offers in_data
//   in_data    producer word (WIDTH bits)
//   in_ready   block can take a word this cycle (flop output)
//   out_valid  out_data holds a valid word (flop output)
//   out_data   oldest held word (flop output, main register M)
//   out_ready  consumer takes out_data this cycle
//   count      number of held words: 0, 1 or 2 (flop output)
// -----------------------------------------------------------------------------
module pipe_skid32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] m_s;
    logic [WIDTH-1:0] s_r;
    logic [WIDTH-1:0] s_s;
    logic             in_ready_r;
    logic             in_ready_s;
    logic             out_valid_r;
    logic             out_valid_s;
    logic [1:0]       count_r;
    logic [1:0]       count_s;
    logic             in_xfer_s;
    logic             out_xfer_s;

    // Handshakes use only flopped readiness, so no input reaches an output
    // combinationally.
    assign in_xfer_s  = in_valid & in_ready_r;
    assign out_xfer_s = out_valid_r & out_ready;

    // Next-state, register-load and next-flag logic.
    always_comb begin
        state_s     = state_r;
        m_s         = m_r;
        s_s         = s_r;
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        count_s     = 2'd0;

        // Flush beats every transfer, and it leaves M/S contents in place.
        if (flush) begin
            state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        m_s     = in_data;
                        state_s = ST_ONE;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        m_s     = in_data;           // pass-through
                        state_s = ST_ONE;
                    end else if (in_xfer_s) begin
                        s_s     = in_data;           // consumer stalled: skid
                        state_s = ST_TWO;
                    end else if (out_xfer_s) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (out_xfer_s) begin
                        m_s     = s_r;               // skid word moves up
                        state_s = ST_ONE;
                    end else begin
                        state_s = ST_TWO;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                end
            endcase
        end

        // Handshake flags and count are decoded from the next state so that
        // they can be flopped and still line up with it.
        case (state_s)
            ST_EMPTY: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
                count_s     = 2'd0;
            end
            ST_ONE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b1;
                count_s     = 2'd1;
            end
            ST_TWO: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
                count_s     = 2'd2;
            end
            default: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
                count_s     = 2'd0;
            end
        endcase
    end

    // State, storage and flag registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_EMPTY;
            m_r         <= {WIDTH{1'b0}};
            s_r         <= {WIDTH{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            count_r     <= 2'd0;
        end else begin
            state_r     <= state_s;
            m_r         <= m_s;
            s_r         <= s_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            count_r     <= count_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = m_r;
    assign count     = count_r;

endmodule

// File: tb/tb_pipe_skid32.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid32 - self-checking bench for pipe_skid32.
//
// The reference model is a FIFO queue of held words with capacity two. Each
// edge pops on an output transfer and pushes on an input transfer, and a
// flush empties it. The model predicts in_ready, out_valid, count and
// out_data for directed scenarios and for a randomized run.
// -----------------------------------------------------------------------------
module tb_pipe_skid32;

    logic        clk;
    logic        clk_en;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [1:0]  count;

    int          total;
    int          passed;
    logic [31:0] q[$];
    bit          last_in_x;

    pipe_skid32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    // Clock can be held still to observe the asynchronous reset.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // Compare every output against the queue model.
    task automatic check_model(input string tag);
        int sz;
        sz = q.size();
        check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, (sz < 2)});
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, (sz > 0)});
        check({tag, ".count"},     {30'd0, count},     sz[31:0]);
        if (sz > 0) check({tag, ".out_data"}, out_data, q[0]);
    endtask

    // One clock edge: model the transfers from pre-edge inputs, then check.
    task automatic cycle(input string tag);
        bit          in_x;
        bit          out_x;
        logic [31:0] d;
        in_x = in_valid && (q.size() < 2);
        out_x = out_ready && (q.size() > 0);
        d = in_data;
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
            in_x = 1'b0;
        end else begin
            if (out_x) void'(q.pop_front());
            if (in_x) q.push_back(d);
        end
        last_in_x = in_x;
        check_model(tag);
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        clk       = 1'b0;
        clk_en    = 1'b0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        last_in_x = 1'b0;

        // Reset with the clock stopped.
        #5;
        reset = 1'b0;
        #1;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.in_ready",  {31'd0, in_ready},  32'd1);
        check("rst.count",     {30'd0, count},     32'd0);
        check("rst.out_data",  out_data,           32'h0000_0000);

        clk_en = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_model("rst_rel");

        // Streaming at full throughput.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            cycle("stream");
            check("stream.word", out_data, i);
            check("stream.count", {30'd0, count}, 32'd1);
        end
        in_valid = 1'b0;
        cycle("stream_end");

        // Stall fill.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hAAAA_0000;
        cycle("fill1");
        in_data   = 32'hBBBB_1111;
        cycle("fill2");
        in_data   = 32'hCCCC_2222;
        cycle("fill3");
        check("fill.count",    {30'd0, count},    32'd2);
        check("fill.in_ready", {31'd0, in_ready}, 32'd0);
        check("fill.out_data", out_data,          32'hAAAA_0000);

        // Drain, with 0xCCCC2222 still offered.
        out_ready = 1'b1;
        cycle("drain1");
        check("drain1.out_data", out_data, 32'hBBBB_1111);
        cycle("drain2");
        check("drain2.out_data", out_data, 32'hCCCC_2222);
        in_valid = 1'b0;
        cycle("drain3");
        check("drain3.out_valid", {31'd0, out_valid}, 32'd0);

        // Flush from TWO while 0xDEADBEEF is offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1111_0001;
        cycle("pf1");
        in_data   = 32'h1111_0002;
        cycle("pf2");
        in_data   = 32'hDEAD_BEEF;
        flush     = 1'b1;
        cycle("flush");
        check("flush.count",     {30'd0, count},     32'd0);
        check("flush.out_valid", {31'd0, out_valid}, 32'd0);
        check("flush.in_ready",  {31'd0, in_ready},  32'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("post_flush");
            check("post_flush.out_valid", {31'd0, out_valid}, 32'd0);
        end

        // Randomized traffic with a stable-until-accepted producer.
        in_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!in_valid || last_in_x) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            cycle("rand");
            if (flush) in_valid = 1'b0;
        end
        flush = 1'b0;

        // Reset in the middle of traffic, asynchronously.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5555_AAAA;
        cycle("pre_rst1");
        in_data   = 32'h6666_BBBB;
        cycle("pre_rst2");
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        check("midrst.out_data",  out_data,           32'h0000_0000);
        check("midrst.count",     {30'd0, count},     32'd0);
        check("midrst.in_ready",  {31'd0, in_ready},  32'd1);
        check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycle("after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_skid32.md
# pipe_skid32

Two-entry valid/ready pipeline register (skid buffer) for the 32-bit MIPS datapath. It accepts words from an upstream producer and presents them to a downstream consumer. This decouples the two sides so that back-pressure never forces a combinational path from `out_ready` to `in_ready`. It replaces bare `flopr`-style stage registers wherever a pipeline stage can stall, and it runs at full throughput when not stalled.

## Interface
- `WIDTH`, 32, data word width in bits

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset; 0 = reset asserted
- `flush`  in  1  synchronous clear; discards all held words
- `in_valid`  in  1  upstream presents a word
- `in_data`  in  WIDTH  upstream word
- `in_ready`  out  1  block can accept a word this cycle (registered)
- `out_valid`  out  1  downstream word available (registered)
- `out_data`  out  WIDTH  downstream word (registered)
- `out_ready`  in  1  downstream accepts the word this cycle
- `count`  out  2  words held: 0, 1 or 2

## Operation
- Storage: main register `M`, which drives `out_data`, and skid register `S`.
- Transfers:
  - Input transfer = `in_valid & in_ready`.
  - Output transfer = `out_valid & out_ready`.
  - Both are evaluated on the same rising edge.
- States:
  - EMPTY (count 0, `in_ready`=1, `out_valid`=0)
  - ONE (count 1, `in_ready`=1, `out_valid`=1)
  - TWO (count 2, `in_ready`=0, `out_valid`=1)
- EMPTY:
  - Input transfer: `M`←`in_data`, go to ONE.
  - Otherwise stay.
  - `out_ready` is ignored.
- ONE:
  - Input and output transfer: `M`←`in_data`, stay ONE (pass-through, throughput 1 word/cycle).
  - Input transfer only: `S`←`in_data`, go to TWO.
  - Output transfer only: go to EMPTY.
  - Neither: hold.
- TWO:
  - Output transfer: `M`←`S`, go to ONE.
  - Otherwise hold.
  - No input transfer is possible because `in_ready`=0.
- Order is strict FIFO. No word is dropped or duplicated except by `flush`.
- `flush`=1 at an edge:
  - Go to EMPTY regardless of state and of `in_valid`/`out_ready`; the word offered that cycle is discarded.
  - Flush has priority over every transfer.
  - `M`/`S` contents are not cleared.
- `out_data` holds its last value while `out_valid`=0. Consumers must not sample it then.
- Producer rule: once `in_valid` rises, `in_data` stays stable until the transfer.
- Consumer side: `out_valid` never drops without an output transfer or a flush.

## Timing
- Reset (`reset`=0, asynchronous, effective immediately without a clock):
  - state EMPTY, `out_valid`=0, `in_ready`=1, `count`=0.
  - `out_data`=0; `S`=0.
- Reset release is synchronous to clk. The first transfer can occur at the first rising edge with `reset`=1.
- Latency: a word accepted at edge N appears on `out_data` with `out_valid`=1 immediately after edge N if the block was EMPTY, or ONE with simultaneous output. Minimum latency is 1 cycle.
- `in_ready`, `out_valid`, `count` and `out_data` are all flop outputs; there are no combinational input-to-output paths.
- `in_ready` drops after the edge that fills `S`. It rises after the edge on which TWO drains to ONE.
- Reset asserted mid-operation: all held words are lost; outputs go to reset values asynchronously.
- `count` always equals the number of held words; `count`=3 is unreachable.

## Test plan
- Reset: drive `reset`=0 with clk stopped -> `out_valid`=0, `in_ready`=1, `count`=0, `out_data`=0x00000000 with no clock edge.
- Streaming: `out_ready`=1, send 0x00000001…0x00000008 on consecutive cycles -> each appears 1 cycle later, in order, `count` stays 1, `in_ready` stays 1.
- Stall fill: `out_ready`=0, send 0xAAAA0000 then 0xBBBB1111 -> `count`=2, `in_ready`=0; 0xCCCC2222 held on input is not accepted; `out_data`=0xAAAA0000.
- Drain: from the stall-fill state, raise `out_ready` -> outputs 0xAAAA0000, then 0xBBBB1111, then 0xCCCC2222 (accepted once `in_ready`=1), then `out_valid`=0.
- Flush: in TWO with `in_valid`=1 and data 0xDEADBEEF -> pulse `flush` -> next cycle `count`=0, `out_valid`=0, `in_ready`=1; 0xDEADBEEF never appears on the output.
- Random valid/ready: 1000 cycles of random `in_valid`/`out_ready` against a scoreboard queue -> zero ordering or data mismatches, and the reported error count is 0.
